signal_period_meter: RTL and testbench

Measures an incoming square wave, such as a divided-down LED toggle or an external test signal, in system-clock cycles. It reports the period and high time of each completed cycle with a one-cycle valid strobe, and flags a stalled input after a timeout. It is the receiving end of the board's clock-divider/toggle generators and is used to check divider outputs in hardware and in simulation.

---
 rtl/signal_period_meter.sv | 146 ++++++++++++++
 tb/tb_signal_period_meter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/signal_period_meter.sv
// signal_period_meter: measures period and high time of an asynchronous
// square wave in system-clock cycles, with a sticky stall flag raised when
// no rising edge arrives within TIMEOUT cycles.
module signal_period_meter #(
   parameter int unsigned CNT_WIDTH = 26,
   parameter int unsigned TIMEOUT   = 50000000
) (
   input  logic                 Clock,
   input  logic                 Resetn,
   input  logic                 sig_in,
   input  logic                 clear,
   output logic [CNT_WIDTH-1:0] period,
   output logic [CNT_WIDTH-1:0] high_time,
   output logic                 valid,
   output logic                 stalled,
   output logic [7:0]           meas_count
);

   localparam logic [CNT_WIDTH-1:0] LP_TMO_LAST = CNT_WIDTH'(TIMEOUT - 1);
   localparam logic [CNT_WIDTH-1:0] LP_ONE      = CNT_WIDTH'(1);

   typedef enum logic {
      S_IDLE    = 1'b0,
      S_MEASURE = 1'b1
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;

   logic                 r_s1;
   logic                 r_s2;
   logic                 r_s3;
   logic                 w_rise;
   logic                 w_fall;

   logic [CNT_WIDTH-1:0] r_cnt;
   logic [CNT_WIDTH-1:0] r_hcnt;
   logic [CNT_WIDTH-1:0] r_period;
   logic [CNT_WIDTH-1:0] r_high_time;
   logic                 r_valid;
   logic                 r_stalled;
   logic [7:0]           r_meas_count;

   logic                 w_tmo_hit;
   logic                 w_complete;
   logic                 w_timeout;
   logic                 w_fall_cap;
   logic                 w_cnt_zero;

   // Synchronizer and edge register; deliberately not affected by clear so
   // an edge in flight is neither lost nor invented.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= sig_in;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   assign w_rise    = r_s2 & ~r_s3;
   assign w_fall    = ~r_s2 & r_s3;
   assign w_tmo_hit = (r_cnt == LP_TMO_LAST);

   // FSM state register.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic: first rise arms, timeout without a rise disarms.
   always_comb begin
      w_state_nxt = r_state;
      if (clear) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:    if (w_rise) w_state_nxt = S_MEASURE;
            S_MEASURE: if (!w_rise && w_tmo_hit) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
         endcase
      end
   end

   // Output decode: per-cycle datapath controls derived from state and edges.
   always_comb begin
      w_complete = 1'b0;
      w_timeout  = 1'b0;
      w_fall_cap = 1'b0;
      w_cnt_zero = 1'b1;
      if (r_state == S_MEASURE) begin
         w_complete = w_rise;
         w_timeout  = !w_rise && w_tmo_hit;
         w_fall_cap = w_fall;
         w_cnt_zero = w_rise || w_tmo_hit;
      end
   end

   // Counters and result registers; clear outranks every event.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         r_cnt        <= '0;
         r_hcnt       <= '0;
         r_period     <= '0;
         r_high_time  <= '0;
         r_valid      <= 1'b0;
         r_stalled    <= 1'b0;
         r_meas_count <= '0;
      end else if (clear) begin
         r_cnt        <= '0;
         r_hcnt       <= '0;
         r_period     <= '0;
         r_high_time  <= '0;
         r_valid      <= 1'b0;
         r_stalled    <= 1'b0;
         r_meas_count <= '0;
      end else begin
         r_valid <= w_complete;
         r_cnt   <= w_cnt_zero ? '0 : r_cnt + LP_ONE;
         if (w_fall_cap) begin
            r_hcnt <= r_cnt + LP_ONE;
         end
         if (w_complete) begin
            r_period     <= r_cnt + LP_ONE;
            r_high_time  <= r_hcnt;
            r_meas_count <= r_meas_count + 8'd1;
            r_stalled    <= 1'b0;
         end else if (w_timeout) begin
            r_stalled <= 1'b1;
         end
      end
   end

   assign period     = r_period;
   assign high_time  = r_high_time;
   assign valid      = r_valid;
   assign stalled    = r_stalled;
   assign meas_count = r_meas_count;

endmodule

// File: tb/tb_signal_period_meter.sv
// Directed testbench for signal_period_meter (TIMEOUT reduced to 50).
module tb_signal_period_meter;

   localparam int unsigned LP_W = 26;

   logic            Clock;
   logic            Resetn;
   logic            sig_in;
   logic            clear;
   logic [LP_W-1:0] period;
   logic [LP_W-1:0] high_time;
   logic            valid;
   logic            stalled;
   logic [7:0]      meas_count;

   int vectors = 0;
   int errors  = 0;
   int tcnt    = 0;

   typedef struct {
      int              t;
      logic [LP_W-1:0] per;
      logic [LP_W-1:0] hi;
      logic [7:0]      mc;
      logic            st;
   } obs_t;

   obs_t q[$];

   signal_period_meter #(
      .CNT_WIDTH(LP_W),
      .TIMEOUT  (50)
   ) dut (
      .Clock     (Clock),
      .Resetn    (Resetn),
      .sig_in    (sig_in),
      .clear     (clear),
      .period    (period),
      .high_time (high_time),
      .valid     (valid),
      .stalled   (stalled),
      .meas_count(meas_count)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // One clock; outputs sampled 1 time unit after the edge, valids logged.
   task automatic tick();
      obs_t o;
      @(posedge Clock);
      #1;
      tcnt++;
      if (valid === 1'b1) begin
         o.t   = tcnt;
         o.per = period;
         o.hi  = high_time;
         o.mc  = meas_count;
         o.st  = stalled;
         q.push_back(o);
      end
   endtask

   // Drive n periods of length p with high time h, then tail low cycles.
   task automatic run_wave(input int p, input int h, input int n, input int tail);
      for (int k = 0; k < n; k++) begin
         for (int i = 0; i < p; i++) begin
            sig_in = (i < h);
            tick();
         end
      end
      for (int i = 0; i < tail; i++) begin
         sig_in = 1'b0;
         tick();
      end
   endtask

   task automatic clear_meter();
      sig_in = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      q.delete();
   endtask

   task automatic test_reset();
      int t0;
      Resetn = 1'b0;
      clear  = 1'b0;
      sig_in = 1'b0;
      for (int i = 0; i < 10; i++) begin
         sig_in = ~sig_in;
         tick();
      end
      vectors++; if (period !== '0) begin errors++; $display("FAIL reset_period got %0d exp 0", period); end
      vectors++; if (high_time !== '0) begin errors++; $display("FAIL reset_high got %0d exp 0", high_time); end
      vectors++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid); end
      vectors++; if (stalled !== 1'b0) begin errors++; $display("FAIL reset_stalled got %b exp 0", stalled); end
      vectors++; if (meas_count !== 8'd0) begin errors++; $display("FAIL reset_mc got %0d exp 0", meas_count); end
      vectors++; if (q.size() !== 0) begin errors++; $display("FAIL reset_no_valid got %0d exp 0", q.size()); end
      Resetn = 1'b1;
      sig_in = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      q.delete();
      t0 = tcnt;
      run_wave(20, 10, 4, 3);
      vectors++; if (q.size() !== 3) begin errors++; $display("FAIL arm_count got %0d exp 3", q.size()); end
      if (q.size() > 0) begin
         vectors++; if (q[0].t !== t0 + 23) begin errors++; $display("FAIL arm_first_valid_tick got %0d exp %0d", q[0].t, t0 + 23); end
      end
      foreach (q[j]) begin
         vectors++; if (q[j].per !== 26'd20) begin errors++; $display("FAIL arm_period[%0d] got %0d exp 20", j, q[j].per); end
         vectors++; if (q[j].hi !== 26'd10) begin errors++; $display("FAIL arm_high[%0d] got %0d exp 10", j, q[j].hi); end
         vectors++; if (q[j].mc !== 8'(j + 1)) begin errors++; $display("FAIL arm_mc[%0d] got %0d exp %0d", j, q[j].mc, j + 1); end
         if (j > 0) begin
            vectors++; if (q[j].t - q[j-1].t !== 20) begin errors++; $display("FAIL arm_spacing[%0d] got %0d exp 20", j, q[j].t - q[j-1].t); end
         end
      end
   endtask

   task automatic test_duty();
      int exp_hi[8] = '{2, 2, 2, 2, 2, 5, 5, 5};
      clear_meter();
      run_wave(7, 2, 5, 0);
      run_wave(7, 5, 4, 3);
      vectors++; if (q.size() !== 8) begin errors++; $display("FAIL duty_count got %0d exp 8", q.size()); end
      foreach (q[j]) begin
         if (j < 8) begin
            vectors++; if (q[j].hi !== 26'(exp_hi[j])) begin errors++; $display("FAIL duty_high[%0d] got %0d exp %0d", j, q[j].hi, exp_hi[j]); end
         end
         vectors++; if (q[j].per !== 26'd7) begin errors++; $display("FAIL duty_period[%0d] got %0d exp 7", j, q[j].per); end
         if (j > 0) begin
            vectors++; if (q[j].t - q[j-1].t !== 7) begin errors++; $display("FAIL duty_spacing[%0d] got %0d exp 7", j, q[j].t - q[j-1].t); end
         end
      end
   endtask

   task automatic test_timeout();
      int last_t;
      int stall_t;
      clear_meter();
      run_wave(20, 10, 3, 0);
      vectors++; if (q.size() !== 2) begin errors++; $display("FAIL tmo_pre_count got %0d exp 2", q.size()); end
      last_t  = (q.size() > 0) ? q[q.size()-1].t : tcnt;
      stall_t = -1;
      for (int k = 0; k < 200 && stall_t < 0; k++) begin
         sig_in = 1'b0;
         tick();
         if (stalled === 1'b1) stall_t = tcnt;
      end
      vectors++;
      if (stall_t < 0) begin
         errors++; $display("FAIL tmo_stall_seen got none exp stall within 200 cycles");
      end else if (stall_t - last_t !== 50) begin
         errors++; $display("FAIL tmo_stall_delay got %0d exp 50", stall_t - last_t);
      end
      vectors++; if (period !== 26'd20) begin errors++; $display("FAIL tmo_period_hold got %0d exp 20", period); end
      vectors++; if (high_time !== 26'd10) begin errors++; $display("FAIL tmo_high_hold got %0d exp 10", high_time); end
      vectors++; if (meas_count !== 8'd2) begin errors++; $display("FAIL tmo_mc_hold got %0d exp 2", meas_count); end
      vectors++; if (q.size() !== 2) begin errors++; $display("FAIL tmo_no_valid got %0d exp 2", q.size()); end
      q.delete();
      run_wave(20, 10, 1, 0);
      vectors++; if (q.size() !== 0) begin errors++; $display("FAIL tmo_rearm_valid got %0d exp 0", q.size()); end
      vectors++; if (stalled !== 1'b1) begin errors++; $display("FAIL tmo_rearm_stalled got %b exp 1", stalled); end
      run_wave(20, 10, 2, 3);
      vectors++; if (q.size() !== 2) begin errors++; $display("FAIL tmo_restart_count got %0d exp 2", q.size()); end
      if (q.size() > 0) begin
         vectors++; if (q[0].st !== 1'b0) begin errors++; $display("FAIL tmo_restart_stall_clr got %b exp 0", q[0].st); end
         vectors++; if (q[0].mc !== 8'd3) begin errors++; $display("FAIL tmo_restart_mc got %0d exp 3", q[0].mc); end
         vectors++; if (q[0].per !== 26'd20) begin errors++; $display("FAIL tmo_restart_period got %0d exp 20", q[0].per); end
      end
   endtask

   task automatic test_boundary();
      clear_meter();
      run_wave(50, 25, 4, 0);
      vectors++; if (q.size() !== 3) begin errors++; $display("FAIL bnd50_count got %0d exp 3", q.size()); end
      foreach (q[j]) begin
         vectors++; if (q[j].per !== 26'd50) begin errors++; $display("FAIL bnd50_period[%0d] got %0d exp 50", j, q[j].per); end
         vectors++; if (q[j].hi !== 26'd25) begin errors++; $display("FAIL bnd50_high[%0d] got %0d exp 25", j, q[j].hi); end
      end
      vectors++; if (stalled !== 1'b0) begin errors++; $display("FAIL bnd50_stalled got %b exp 0", stalled); end
      clear_meter();
      run_wave(51, 25, 4, 0);
      vectors++; if (q.size() !== 0) begin errors++; $display("FAIL bnd51_valid got %0d exp 0", q.size()); end
      vectors++; if (stalled !== 1'b1) begin errors++; $display("FAIL bnd51_stalled got %b exp 1", stalled); end
      vectors++; if (meas_count !== 8'd0) begin errors++; $display("FAIL bnd51_mc got %0d exp 0", meas_count); end
   endtask

   task automatic test_clear_wrap();
      clear_meter();
      run_wave(20, 10, 3, 0);
      vectors++; if (meas_count !== 8'd2) begin errors++; $display("FAIL clr_pre_mc got %0d exp 2", meas_count); end
      for (int i = 0; i < 20; i++) begin
         sig_in = (i < 10);
         clear  = (i == 5);
         tick();
         if (i == 5) begin
            vectors++; if (period !== '0) begin errors++; $display("FAIL clr_period got %0d exp 0", period); end
            vectors++; if (high_time !== '0) begin errors++; $display("FAIL clr_high got %0d exp 0", high_time); end
            vectors++; if (meas_count !== 8'd0) begin errors++; $display("FAIL clr_mc got %0d exp 0", meas_count); end
            vectors++; if (valid !== 1'b0) begin errors++; $display("FAIL clr_valid got %b exp 0", valid); end
         end
      end
      clear = 1'b0;
      q.delete();
      run_wave(20, 10, 2, 3);
      vectors++; if (q.size() !== 1) begin errors++; $display("FAIL clr_rearm_count got %0d exp 1", q.size()); end
      if (q.size() > 0) begin
         vectors++; if (q[0].mc !== 8'd1) begin errors++; $display("FAIL clr_rearm_mc got %0d exp 1", q[0].mc); end
         vectors++; if (q[0].per !== 26'd20) begin errors++; $display("FAIL clr_rearm_period got %0d exp 20", q[0].per); end
      end
      clear_meter();
      run_wave(4, 2, 258, 3);
      vectors++; if (q.size() !== 257) begin errors++; $display("FAIL wrap_count got %0d exp 257", q.size()); end
      foreach (q[j]) begin
         vectors++; if (q[j].mc !== 8'(j + 1)) begin errors++; $display("FAIL wrap_mc[%0d] got %0d exp %0d", j, q[j].mc, (j + 1) % 256); end
         vectors++; if (q[j].per !== 26'd4) begin errors++; $display("FAIL wrap_period[%0d] got %0d exp 4", j, q[j].per); end
      end
      vectors++; if (meas_count !== 8'd1) begin errors++; $display("FAIL wrap_final_mc got %0d exp 1", meas_count); end
   endtask

   task automatic test_min_period();
      clear_meter();
      run_wave(2, 1, 10, 3);
      vectors++; if (q.size() !== 9) begin errors++; $display("FAIL min_count got %0d exp 9", q.size()); end
      foreach (q[j]) begin
         vectors++; if (q[j].per !== 26'd2) begin errors++; $display("FAIL min_period[%0d] got %0d exp 2", j, q[j].per); end
         vectors++; if (q[j].hi !== 26'd1) begin errors++; $display("FAIL min_high[%0d] got %0d exp 1", j, q[j].hi); end
         if (j > 0) begin
            vectors++; if (q[j].t - q[j-1].t !== 2) begin errors++; $display("FAIL min_spacing[%0d] got %0d exp 2", j, q[j].t - q[j-1].t); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_duty();
      test_timeout();
      test_boundary();
      test_clear_wrap();
      test_min_period();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
